// File: rtl/huffman_stream_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : huffman_stream_packer                                             |
// | Brief  : Huffman encode stage. Loadable per-symbol code table, one-cycle   |
// |          lookup, MSB-first bit packing into OUT_W-bit words with a         |
// |          zero-padded final word tagged with its valid-bit count.           |
// | Option : HUFF_BITCNT_EN - builds the per-stream appended-bit counter;      |
// |          when undefined bit_count is tied to zero.                         |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module huffman_stream_packer #(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 16,
  parameter int OUT_W   = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int NB_W    = $clog2(OUT_W + 1)
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               tbl_we,
  input  logic [SYM_W-1:0]   tbl_addr,
  input  logic [LEN_W-1:0]   tbl_len,
  input  logic [MAX_LEN-1:0] tbl_code,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SYM_W-1:0]   in_sym,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [NB_W-1:0]    out_nbits,
  output logic               out_last,
  output logic               busy,
  output logic [31:0]        bit_count
);

  localparam int c_DEPTH  = 1 << SYM_W;
  localparam int c_ACC_W  = 2 * OUT_W;
  localparam int c_FILL_W = $clog2(c_ACC_W + 1);
  localparam logic [c_FILL_W-1:0] c_OUT_W_F = c_FILL_W'(OUT_W);
  localparam logic [c_FILL_W-1:0] c_ACC_W_F = c_FILL_W'(c_ACC_W);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_FLUSH = 2'd2;

  logic [1:0]          r_state;
  logic                r_rst_done;
  logic [LEN_W-1:0]    r_tbl_len  [c_DEPTH];
  logic [MAX_LEN-1:0]  r_tbl_code [c_DEPTH];
  logic                r_s1_valid;
  logic [LEN_W-1:0]    r_s1_len;
  logic [MAX_LEN-1:0]  r_s1_code;
  logic                r_s1_last;
  logic [c_ACC_W-1:0]  r_acc;
  logic [c_FILL_W-1:0] r_fill;
  logic                r_out_valid;
  logic [OUT_W-1:0]    r_out_data;
  logic [NB_W-1:0]     r_out_nbits;
  logic                r_out_last;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_tbl_wr;
  logic [MAX_LEN-1:0]  w_tbl_mask;
  logic                w_out_free;
  logic                w_full;
  logic                w_ext_final;
  logic                w_ext;
  logic [c_FILL_W-1:0] w_ext_bits;
  logic [c_FILL_W-1:0] w_app_len;
  logic [c_FILL_W-1:0] w_fill_base;
  logic [c_FILL_W-1:0] w_shamt;
  logic [c_ACC_W-1:0]  w_code_ext;
  logic [c_ACC_W-1:0]  w_acc_base;
  logic [c_ACC_W-1:0]  w_acc_next;

  // Input gating: open only in IDLE/RUN below one word of fill, held low out of
  // reset until the first clock, and closed while a closing symbol sits in
  // lookup so the next stream cannot slip into this one's flush.
  assign w_in_ready = r_rst_done
                   && (r_state == c_ST_IDLE || r_state == c_ST_RUN)
                   && (r_fill < c_OUT_W_F)
                   && !(r_s1_valid && r_s1_last);
  assign w_accept   = in_valid && w_in_ready;

  // Table writes only land when nothing is in flight.
  assign w_tbl_wr   = tbl_we && (r_state == c_ST_IDLE) && !r_s1_valid;
  assign w_tbl_mask = ~({MAX_LEN{1'b1}} << tbl_len);

  // Extraction: a full word whenever one is available and the output register
  // can take it; during FLUSH the remainder (<= one word) closes the stream.
  assign w_out_free  = !r_out_valid || out_ready;
  assign w_full      = (r_fill >= c_OUT_W_F);
  assign w_ext_final = (r_state == c_ST_FLUSH) && w_out_free && (r_fill <= c_OUT_W_F);
  assign w_ext       = (w_full && w_out_free) || w_ext_final;
  assign w_ext_bits  = !w_ext ? '0 : (w_full ? c_OUT_W_F : r_fill);

  // Append: the code lands immediately below whatever fill remains after any
  // extraction in the same cycle. len 0 entries hold a zero code, so they add
  // nothing even though the OR is still performed.
  assign w_app_len   = r_s1_valid ? c_FILL_W'(r_s1_len) : '0;
  assign w_fill_base = r_fill - w_ext_bits;
  assign w_shamt     = c_ACC_W_F - w_fill_base - w_app_len;
  assign w_code_ext  = {{(c_ACC_W - MAX_LEN){1'b0}}, r_s1_code};
  assign w_acc_base  = w_ext ? (r_acc << OUT_W) : r_acc;
  assign w_acc_next  = w_acc_base | (r_s1_valid ? (w_code_ext << w_shamt) : '0);

  // Reset-release flag keeps in_ready low until the first clock after reset.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) r_rst_done <= 1'b0;
    else      r_rst_done <= 1'b1;
  end

  // Code table storage; entries stored with bits at or above len cleared.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_tbl_len[i]  <= '0;
        r_tbl_code[i] <= '0;
      end
    end else if (w_tbl_wr) begin
      r_tbl_len[tbl_addr]  <= tbl_len;
      r_tbl_code[tbl_addr] <= tbl_code & w_tbl_mask;
    end
  end

  // Stage 1: register the looked-up entry and last flag of an accepted symbol.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_len   <= '0;
      r_s1_code  <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_len   <= r_tbl_len[in_sym];
      r_s1_code  <= r_tbl_code[in_sym];
      r_s1_last  <= in_last;
    end else begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: MSB-aligned accumulator and its fill count.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_fill <= '0;
    end else begin
      r_acc  <= w_acc_next;
      r_fill <= w_fill_base + w_app_len;
    end
  end

  // Output register: loads on extraction, otherwise holds until read.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_nbits <= '0;
      r_out_last  <= 1'b0;
    end else if (w_ext) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_acc[c_ACC_W-1 -: OUT_W];
      r_out_nbits <= w_full ? NB_W'(OUT_W) : NB_W'(r_fill);
      r_out_last  <= w_ext_final;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Stream control: IDLE -> RUN on first symbol, RUN -> FLUSH when the closing
  // symbol is appended, FLUSH -> IDLE once the final word is issued.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE:  if (w_accept)                 r_state <= c_ST_RUN;
        c_ST_RUN:   if (r_s1_valid && r_s1_last)  r_state <= c_ST_FLUSH;
        c_ST_FLUSH: if (w_ext_final)              r_state <= c_ST_IDLE;
        default:                                  r_state <= c_ST_IDLE;
      endcase
    end
  end

`ifdef HUFF_BITCNT_EN
  logic [31:0] r_bit_count;
  logic [32:0] w_bc_sum;

  assign w_bc_sum = {1'b0, r_bit_count} + 33'(r_s1_len);

  // Per-stream appended-bit counter: cleared when a stream opens, saturating.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_bit_count <= '0;
    end else if (w_accept && (r_state == c_ST_IDLE)) begin
      r_bit_count <= '0;
    end else if (r_s1_valid) begin
      r_bit_count <= w_bc_sum[32] ? 32'hFFFF_FFFF : w_bc_sum[31:0];
    end
  end

  assign bit_count = r_bit_count;
`else
  assign bit_count = 32'd0;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_nbits = r_out_nbits;
  assign out_last  = r_out_last;
  assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_huffman_stream_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_huffman_stream_packer                                          |
// | Brief  : Self-checking bench for huffman_stream_packer. Expected words come|
// |          from a bit-queue model of the code table and stream.              |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_huffman_stream_packer;

  localparam int SYM_W   = 8;
  localparam int MAX_LEN = 16;
  localparam int OUT_W   = 32;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int NB_W    = $clog2(OUT_W + 1);

  logic               clock = 1'b0;
  logic               rst = 1'b0;
  logic               tbl_we = 1'b0;
  logic [SYM_W-1:0]   tbl_addr = '0;
  logic [LEN_W-1:0]   tbl_len = '0;
  logic [MAX_LEN-1:0] tbl_code = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [SYM_W-1:0]   in_sym = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [OUT_W-1:0]   out_data;
  logic [NB_W-1:0]    out_nbits;
  logic               out_last;
  logic               busy;
  logic [31:0]        bit_count;

  huffman_stream_packer #(
    .SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .OUT_W(OUT_W), .LEN_W(LEN_W), .NB_W(NB_W)
  ) dut (
    .clock(clock), .rst(rst),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_len(tbl_len), .tbl_code(tbl_code),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_nbits(out_nbits), .out_last(out_last), .busy(busy), .bit_count(bit_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference table and stream
  logic [LEN_W-1:0]   mt_len  [256];
  logic [MAX_LEN-1:0] mt_code [256];
  logic [SYM_W-1:0]   sq_sym [$];
  logic [OUT_W-1:0]   ex_data [$];
  logic [NB_W-1:0]    ex_nbits [$];
  bit                 ex_last [$];
  int                 ex_bits;

  // Observed output words and accepted-symbol count
  logic [OUT_W-1:0]   got_data [$];
  logic [NB_W-1:0]    got_nbits [$];
  bit                 got_last [$];
  int                 last_cnt = 0;
  int                 acc_cnt = 0;
  int                 last_base;

  // Handshakes resolve at the next rising edge; values are stable here.
  always @(negedge clock) begin
    if (rst && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_nbits.push_back(out_nbits);
      got_last.push_back(out_last);
      if (out_last) last_cnt++;
    end
    if (rst && in_valid && in_ready) acc_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] exp_bitcount(input int bits);
`ifdef HUFF_BITCNT_EN
    return 32'(bits);
`else
    return 32'd0 + 32'(bits - bits);
`endif
  endfunction

  task automatic write_entry(input int a, input int l, input int c, input bit upd);
    logic [MAX_LEN-1:0] m;
    tbl_we = 1'b1; tbl_addr = SYM_W'(a); tbl_len = LEN_W'(l); tbl_code = MAX_LEN'(c);
    tick();
    tbl_we = 1'b0;
    if (upd) begin
      m = '0;
      for (int b = 0; b < l; b++) m[b] = 1'b1;
      mt_len[a]  = LEN_W'(l);
      mt_code[a] = MAX_LEN'(c) & m;
    end
  endtask

  // Concatenate every code MSB-first, then cut into OUT_W-bit words.
  task automatic build_expect();
    bit bq [$];
    logic [OUT_W-1:0] w;
    int k;
    ex_data.delete(); ex_nbits.delete(); ex_last.delete();
    foreach (sq_sym[i]) begin
      int l;
      l = int'(mt_len[sq_sym[i]]);
      for (int b = l - 1; b >= 0; b--) bq.push_back(mt_code[sq_sym[i]][b]);
    end
    ex_bits = bq.size();
    if (bq.size() == 0) begin
      ex_data.push_back('0); ex_nbits.push_back('0); ex_last.push_back(1'b1);
    end
    while (bq.size() > 0) begin
      k = (bq.size() < OUT_W) ? bq.size() : OUT_W;
      w = '0;
      for (int j = 0; j < k; j++) w[OUT_W-1-j] = bq.pop_front();
      ex_data.push_back(w); ex_nbits.push_back(NB_W'(k)); ex_last.push_back(bq.size() == 0);
    end
  endtask

  task automatic drive_syms(input bit dense);
    int i = 0;
    int cyc = 0;
    while (i < sq_sym.size() && cyc < 4000) begin
      in_valid = dense || ($urandom_range(0, 3) != 0);
      in_sym   = sq_sym[i];
      in_last  = (i == sq_sym.size() - 1);
      @(negedge clock);
      if (in_valid && in_ready) i++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++;
    if (i != sq_sym.size()) begin
      n_err++;
      $display("FAIL drive_timeout: accepted %0d symbols, required %0d", i, sq_sym.size());
    end
  endtask

  // mode 0: always ready, 1: random, 2: low for 'stall' cycles then high
  task automatic drive_ready(input int mode, input int stall);
    int cyc = 0;
    while (last_cnt == last_base && cyc < 4000) begin
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = ($urandom_range(0, 2) != 0);
      else                out_ready = (cyc >= stall);
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    n_cmp++;
    if (last_cnt == last_base) begin
      n_err++;
      $display("FAIL stream_timeout: no final word after %0d cycles, required out_last", cyc);
    end
  endtask

  task automatic start_stream();
    got_data.delete(); got_nbits.delete(); got_last.delete();
    last_base = last_cnt;
    build_expect();
  endtask

  task automatic run_stream(input bit dense, input int mode);
    start_stream();
    fork
      drive_syms(dense);
      drive_ready(mode, 0);
    join
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_nbits !== '0 ||
        out_last !== 1'b0 || busy !== 1'b0 || bit_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%b ov=%b d=%h nb=%0d ol=%b busy=%b bc=%0d, required all 0",
               in_ready, out_valid, out_data, out_nbits, out_last, busy, bit_count);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_pack_flush();
    write_entry(8'h41, 2, 16'hFFFE, 1'b1);
    write_entry(8'h42, 3, 16'hFFFD, 1'b1);
    sq_sym = '{8'h41, 8'h42, 8'h41};
    run_stream(1'b1, 0);
    n_cmp++;
    if (got_data.size() != 1) begin
      n_err++;
      $display("FAIL pack_count: got %0d words, required 1", got_data.size());
    end else begin
      n_cmp++;
      if (got_data[0] !== 32'hAC00_0000 || got_nbits[0] !== NB_W'(7) || got_last[0] !== 1'b1) begin
        n_err++;
        $display("FAIL pack_word: got %h/%0d/%b, required ac000000/7/1", got_data[0], got_nbits[0], got_last[0]);
      end
    end
    n_cmp++;
    if (bit_count !== exp_bitcount(7) || busy !== 1'b0) begin
      n_err++;
      $display("FAIL pack_bitcount: got bc=%0d busy=%b, required bc=%0d busy=0", bit_count, busy, exp_bitcount(7));
    end
  endtask

  task automatic test_exact_boundary();
    write_entry(8'h43, 2, 16'h0003, 1'b1);
    sq_sym.delete();
    repeat (16) sq_sym.push_back(8'h43);
    run_stream(1'b1, 0);
    n_cmp++;
    if (got_data.size() != 1) begin
      n_err++;
      $display("FAIL boundary_count: got %0d words, required 1", got_data.size());
    end else begin
      n_cmp++;
      if (got_data[0] !== 32'hFFFF_FFFF || got_nbits[0] !== NB_W'(32) || got_last[0] !== 1'b1) begin
        n_err++;
        $display("FAIL boundary_word: got %h/%0d/%b, required ffffffff/32/1", got_data[0], got_nbits[0], got_last[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    write_entry(8'h44, 16, 16'hA5A5, 1'b1);
    sq_sym.delete();
    repeat (40) sq_sym.push_back(8'h44);
    start_stream();
    base = acc_cnt;
    fork
      drive_syms(1'b1);
      drive_ready(2, 20);
      begin
        repeat (19) tick();
        @(negedge clock);
        n_cmp++;
        if (in_ready !== 1'b0 || got_data.size() != 0) begin
          n_err++;
          $display("FAIL stall_ready: got in_ready=%b words=%0d, required 0/0", in_ready, got_data.size());
        end
        n_cmp++;
        if ((acc_cnt - base) < 2 || (acc_cnt - base) * 16 > OUT_W + OUT_W - 1 + 2 * MAX_LEN) begin
          n_err++;
          $display("FAIL stall_accepted: got %0d symbols, required 2..%0d", acc_cnt - base,
                   (2 * OUT_W - 1 + 2 * MAX_LEN) / 16);
        end
      end
    join
    repeat (4) tick();
    n_cmp++;
    if (got_data.size() != 20) begin
      n_err++;
      $display("FAIL bp_count: got %0d words, required 20", got_data.size());
    end else begin
      foreach (got_data[j]) begin
        n_cmp++;
        if (got_data[j] !== 32'hA5A5_A5A5 || got_nbits[j] !== NB_W'(32) || got_last[j] !== (j == 19)) begin
          n_err++;
          $display("FAIL bp_word%0d: got %h/%0d/%b, required a5a5a5a5/32/%0d", j, got_data[j],
                   got_nbits[j], got_last[j], (j == 19));
        end
      end
    end
  endtask

  task automatic test_unmapped();
    sq_sym = '{8'h99};
    run_stream(1'b1, 0);
    n_cmp++;
    if (got_data.size() != 1 || got_data[0] !== '0 || got_nbits[0] !== '0 || got_last[0] !== 1'b1 ||
        busy !== 1'b0 || bit_count !== 32'd0) begin
      n_err++;
      $display("FAIL unmapped: got %0d words busy=%b bc=%0d, required one 0/0/last word, busy 0, bc 0",
               got_data.size(), busy, bit_count);
    end
  endtask

  task automatic test_table_gating();
    int cyc = 0;
    start_stream();
    in_valid = 1'b1; in_sym = 8'h41; in_last = 1'b1;
    @(negedge clock);
    while (!in_ready && cyc < 100) begin
      tick(); @(negedge clock); cyc++;
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tbl_we = 1'b1; tbl_addr = 8'h41; tbl_len = LEN_W'(1); tbl_code = '0;
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL gating_busy: got busy=%b during write, required 1", busy);
    end
    tick();
    tbl_we = 1'b0;
    cyc = 0;
    while (last_cnt == last_base && cyc < 100) begin tick(); cyc++; end
    n_cmp++;
    if (got_data.size() != 1 || got_data[0] !== 32'h8000_0000 || got_nbits[0] !== NB_W'(2)) begin
      n_err++;
      $display("FAIL gating_inflight: got %0d words first=%h, required 1 word 80000000/2",
               got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'h0);
    end
    sq_sym = '{8'h41};
    run_stream(1'b1, 0);
    n_cmp++;
    if (got_data.size() != 1 || got_data[0] !== 32'h8000_0000 || got_nbits[0] !== NB_W'(2)) begin
      n_err++;
      $display("FAIL gating_restream: got %0d words first=%h, required 1 word 80000000/2",
               got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'h0);
    end
  endtask

  task automatic test_random_streams();
    for (int s = 0; s < 8; s++) begin
      for (int a = 8'h10; a < 8'h1C; a++)
        write_entry(a, (a == 8'h10) ? $urandom_range(1, MAX_LEN) : $urandom_range(0, MAX_LEN),
                    $urandom_range(0, 16'hFFFF), 1'b1);
      sq_sym.delete();
      repeat ($urandom_range(0, 39)) sq_sym.push_back(SYM_W'($urandom_range(8'h10, 8'h1B)));
      sq_sym.push_back(8'h10);
      run_stream(1'b0, 1);
      n_cmp++;
      if (got_data.size() != ex_data.size()) begin
        n_err++;
        $display("FAIL rand%0d_count: got %0d words, required %0d", s, got_data.size(), ex_data.size());
      end else begin
        foreach (ex_data[j]) begin
          n_cmp++;
          if (got_data[j] !== ex_data[j] || got_nbits[j] !== ex_nbits[j] || got_last[j] !== ex_last[j]) begin
            n_err++;
            $display("FAIL rand%0d_word%0d: got %h/%0d/%b, required %h/%0d/%b", s, j, got_data[j],
                     got_nbits[j], got_last[j], ex_data[j], ex_nbits[j], ex_last[j]);
          end
        end
      end
      n_cmp++;
      if (bit_count !== exp_bitcount(ex_bits) || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rand%0d_bitcount: got bc=%0d busy=%b, required bc=%0d busy=0", s, bit_count,
                 busy, exp_bitcount(ex_bits));
      end
    end
  endtask

  task automatic test_reset_midstream();
    write_entry(8'h45, 10, $urandom_range(0, 16'hFFFF), 1'b1);
    in_valid = 1'b1; in_sym = 8'h45; in_last = 1'b0;
    repeat (2) tick();
    in_valid = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midstream_pre: got busy=%b ov=%b with 20 bits held, required 1/0", busy, out_valid);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_nbits !== '0 ||
        out_last !== 1'b0 || busy !== 1'b0 || bit_count !== 32'd0) begin
      n_err++;
      $display("FAIL midstream_reset: got rdy=%b ov=%b d=%h nb=%0d ol=%b busy=%b bc=%0d, required all 0",
               in_ready, out_valid, out_data, out_nbits, out_last, busy, bit_count);
    end
    for (int a = 0; a < 256; a++) begin mt_len[a] = '0; mt_code[a] = '0; end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    sq_sym = '{8'h45};
    run_stream(1'b1, 0);
    n_cmp++;
    if (got_data.size() != 1 || got_data[0] !== '0 || got_nbits[0] !== '0 || got_last[0] !== 1'b1) begin
      n_err++;
      $display("FAIL midstream_table: got %0d words, required one 0/0/last word", got_data.size());
    end
    write_entry(8'h45, 10, $urandom_range(0, 16'hFFFF), 1'b1);
    sq_sym = '{8'h45, 8'h45};
    run_stream(1'b1, 0);
    n_cmp++;
    if (got_data.size() != 1 || got_data[0] !== ex_data[0] || got_nbits[0] !== NB_W'(20) ||
        got_last[0] !== 1'b1) begin
      n_err++;
      $display("FAIL midstream_clean: got %0d words first=%h, required 1 word %h/20",
               got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'h0, ex_data[0]);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin mt_len[a] = '0; mt_code[a] = '0; end
    test_reset();
    test_pack_flush();
    test_exact_boundary();
    test_backpressure();
    test_unmapped();
    test_table_gating();
    test_random_streams();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/huffman_stream_packer.md
# huffman_stream_packer

Parametrised Huffman encode stage that follows code-table generation. Holds a loadable per-symbol code table (length + code word), looks up each incoming symbol, and packs the variable-length codes MSB-first into fixed-width output words under valid/ready handshakes on both sides. Closes each stream with a zero-padded final word tagged with its valid-bit count.

## Interface
- SYM_W, 8: symbol width; table depth is 2^SYM_W.
- MAX_LEN, 16: maximum code length. Constraint: 2*MAX_LEN <= OUT_W.
- OUT_W, 32: output word width.
- LEN_W, derived: $clog2(MAX_LEN+1).
- NB_W, derived: $clog2(OUT_W+1).
- clock  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  SYM_W  symbol being written.
- tbl_len  in  LEN_W  code length; 0 means unmapped.
- tbl_code  in  MAX_LEN  code, right-aligned; bits at or above tbl_len are ignored.
- in_valid  in  1  symbol valid.
- in_ready  out  1  symbol accepted when in_valid && in_ready.
- in_sym  in  SYM_W  symbol.
- in_last  in  1  final symbol of stream.
- out_valid  out  1  word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  packed bits; first code bit is at the MSB.
- out_nbits  out  NB_W  valid bits in out_data: OUT_W, or fewer on the final word.
- out_last  out  1  final word of stream.
- busy  out  1  state != IDLE.
- bit_count  out  32  code bits appended in the current/last stream (see Configuration).

## Operation
- Table: 2^SYM_W entries of {len, code}, all reset to 0.
  - A write takes effect only when state == IDLE and the lookup stage is empty; otherwise it is ignored.
  - Value written is masked: code & ((1<<len)-1).
- Stage 1, lookup: an accepted symbol is registered with its table entry and last flag.
- Stage 2, accumulator:
  - 2*OUT_W bits wide; fill_q counts its valid bits.
  - Stage 1 appends len bits immediately below the existing fill.
  - len == 0 appends nothing; the symbol is dropped, but its last flag is still honoured.
- Extraction:
  - Condition: fill_q >= OUT_W, and the output register is empty or being read (out_valid && out_ready).
  - Action: the top OUT_W bits move to out_data with out_nbits = OUT_W, then shift up; fill decreases by OUT_W.
  - Append and extraction in the same cycle combine: fill_next = fill_q - (ext ? OUT_W : 0) + len.
- in_ready = (state == IDLE || state == RUN) && fill_q < OUT_W.
- States:
  - IDLE -> RUN on the first accepted symbol.
  - RUN -> FLUSH when stage 1 appends a symbol with last = 1 (also if that is the first symbol of the stream).
  - FLUSH: in_ready = 0. Full words are extracted normally.
    - Extraction with fill_q == OUT_W exactly: out_last = 1, out_nbits = OUT_W, -> IDLE.
    - fill_q < OUT_W with the output register free: emit the remaining bits left-aligned, LSBs zero-padded, out_nbits = fill_q, out_last = 1, -> IDLE.
    - fill_q == 0 gives a word of 0, out_nbits = 0, out_last = 1.
- Output register holds its data stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready 0 during reset (1 the cycle after release), out_valid 0, out_data 0, out_nbits 0, out_last 0, busy 0, bit_count 0.
- Reset clears state, fill, stage 1 and the table, mid-stream included. A partially packed stream is discarded.
- Symbol accepted in cycle N -> appended in N+1 -> earliest out_valid in N+2.
- Throughput: one symbol per cycle while fill_q < OUT_W. in_ready falls the cycle after fill_q reaches OUT_W.
- Overflow bound: fill never exceeds OUT_W-1+2*MAX_LEN <= 2*OUT_W-1.
- A table write in cycle N is visible to a symbol accepted in N+1 or later.

## Configuration
- HUFF_BITCNT_EN defined:
  - bit_count clears on the first accepted symbol of a stream.
  - It increments by each appended len, saturates at 2^32-1, and holds after out_last until the next stream.
- HUFF_BITCNT_EN undefined: bit_count is tied to 0 and the counter is not built.

## Test plan
- Pack and flush:
  - Stimulus: table 0x41 = {2, 2'b10}, 0x42 = {3, 3'b101}; stream 0x41, 0x42, 0x41(last).
  - Response: one word 0xAC000000, out_nbits 7, out_last 1. bit_count 7 with HUFF_BITCNT_EN.
- Exact boundary:
  - Stimulus: 16 symbols of {2, 2'b11}, last on the 16th.
  - Response: single word 0xFFFFFFFF, out_nbits 32, out_last 1; no extra word.
- Backpressure:
  - Stimulus: 40 symbols of {16, 0xA5A5} with out_ready held 0 for 20 cycles, then 1.
  - Response: in_ready drops at fill >= 32; 20 words of 0xA5A5A5A5 delivered, the last with out_nbits 32 and out_last 1; no loss or duplication.
- Unmapped symbol:
  - Stimulus: a single len-0 symbol with last.
  - Response: word 0, out_nbits 0, out_last 1; busy returns to 0.
- Table-write gating:
  - Stimulus: tbl_we for 0x41 = {1, 1'b0} while busy; then restream 0x41(last).
  - Response: old code used, word 0x80000000, out_nbits 2.
- Reset mid-stream:
  - Stimulus: assert rst with fill 20.
  - Response: outputs at reset values immediately; table len 0; a new stream starts clean.
